// File: rtl/uncached_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uncached_pkg
// Brief    : Shared encodings for the uncached bus bridge and the decoder.
// Revision : 1.0
// ============================================================================
package uncached_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Decoder tag for the MMIO window; undecoded regions also route here.
    localparam logic [9:0] MMIO_TAG   = 10'h1;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;

endpackage : uncached_pkg
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : bus_timeout_counter
// Brief    : Saturating wait counter with a hit flag at TIMEOUT_CYCLES.
// Revision : 1.0
// ============================================================================
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic saturated,
    output logic hit
);

    localparam int          CW      = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !saturated) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign saturated = (r_count == C_LIMIT);

    // A zero limit disables the timeout entirely.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_timeout_off
            assign hit = 1'b0;
        end else begin : g_timeout_on
            assign hit = saturated;
        end
    endgenerate

endmodule : bus_timeout_counter
`default_nettype wire

// File: rtl/uncached_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uncached_bus_bridge
// Brief    : Forwards one non-cacheable core access onto the peripheral bus,
//            stalling the core until the slave answers or the access times out.
// Revision : 1.0
// ============================================================================
module uncached_bus_bridge
    import uncached_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    input  logic        core_we,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_wstrb,
    input  logic        cache_enable,
    output logic        core_stall,
    output logic        core_done,
    output logic        core_err,
    output logic [31:0] core_rdata,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        w_accept;
    logic        w_in_req;
    logic        w_cnt_sat;
    logic        w_cnt_hit;
    logic        w_timeout;

    logic        r_bus_valid;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    assign w_accept = core_req && !cache_enable;
    assign w_in_req = (r_state == ST_REQ);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     ((r_state == ST_IDLE) && w_accept),
        .enable    (w_in_req && !bus_ready && !w_cnt_sat),
        .saturated (w_cnt_sat),
        .hit       (w_cnt_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)              w_state_nxt = ST_REQ;
            ST_REQ:  if (bus_ready || w_cnt_hit) w_state_nxt = ST_DONE;
            ST_DONE:                            w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        core_stall = ((r_state == ST_IDLE) && w_accept) || w_in_req;
        // A ready on the limit cycle wins over the timeout.
        w_timeout  = w_in_req && !bus_ready && w_cnt_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= WSTRB_NONE;
        end else begin
            r_bus_valid <= (w_state_nxt == ST_REQ);
            r_done      <= (w_state_nxt == ST_DONE);
            r_err       <= 1'b0;
            if ((r_state == ST_IDLE) && w_accept) begin
                r_addr  <= core_addr;
                r_we    <= core_we;
                r_wdata <= core_wdata;
                r_wstrb <= core_we ? core_wstrb : WSTRB_NONE;
            end
            if (w_in_req && bus_ready) begin
                r_err <= bus_err;
                if (!r_we) begin
                    r_rdata <= bus_rdata;
                end
            end else if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end
        end
    end

    assign bus_valid  = r_bus_valid;
    assign bus_addr   = r_addr;
    assign bus_we     = r_we;
    assign bus_wdata  = r_wdata;
    assign bus_wstrb  = r_wstrb;
    assign core_done  = r_done;
    assign core_err   = r_err;
    assign core_rdata = r_rdata;

endmodule : uncached_bus_bridge
`default_nettype wire

// File: tb/tb_uncached_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uncached_bus_bridge
// Brief    : Scoreboard bench for uncached_bus_bridge with a 4-cycle timeout.
// Revision : 1.0
// ============================================================================
module tb_uncached_bus_bridge;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req;
    logic [31:0] core_addr;
    logic        core_we;
    logic [31:0] core_wdata;
    logic [3:0]  core_wstrb;
    logic        cache_enable;
    logic        core_stall;
    logic        core_done;
    logic        core_err;
    logic [31:0] core_rdata;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    logic [31:0] model_rdata = 32'h0;

    uncached_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_req     (core_req),
        .core_addr    (core_addr),
        .core_we      (core_we),
        .core_wdata   (core_wdata),
        .core_wstrb   (core_wstrb),
        .cache_enable (cache_enable),
        .core_stall   (core_stall),
        .core_done    (core_done),
        .core_err     (core_err),
        .core_rdata   (core_rdata),
        .bus_valid    (bus_valid),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (core_done === 1'b1) done_cnt++;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for the current cycle and record its expected completion.
    task automatic drive_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                             input logic [3:0] ws, input bit expect_done, input logic e_err,
                             input logic [31:0] e_rdata);
        exp_t e;
        core_req = 1'b1; core_addr = a; core_we = we; core_wdata = wd;
        core_wstrb = ws; cache_enable = 1'b0;
        if (expect_done) begin
            e.err = e_err; e.rdata = e_rdata;
            sb.push_back(e);
            model_rdata = e_rdata;
        end
    endtask

    task automatic check_done(input string name);
        exp_t e;
        checks++;
        if (core_done !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL %s done: got %b want 1 (queued=%0d)", name, core_done, sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (core_err !== e.err) begin
            failures++;
            $display("FAIL %s err: got %b want %b", name, core_err, e.err);
        end
        checks++;
        if (core_rdata !== e.rdata) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", name, core_rdata, e.rdata);
        end
        checks++;
        if (core_stall !== 1'b0 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s done_cycle stall/valid: got %b/%b want 0/0", name, core_stall, bus_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus_valid, core_done, core_err, bus_we, core_stall} !== 5'b0 ||
            core_rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wstrb !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: got v%b d%b e%b we%b st%b rd%h a%h wd%h ws%h want all 0",
                     bus_valid, core_done, core_err, bus_we, core_stall, core_rdata, bus_addr, bus_wdata, bus_wstrb);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        next_cycle();
        drive_req(32'h0040_0010, 1'b0, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b1 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_c0 stall/valid: got %b/%b want 1/0", core_stall, bus_valid);
        end
        next_cycle();
        core_req = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (bus_valid !== 1'b1 || core_stall !== 1'b1 || bus_addr !== 32'h0040_0010 ||
            bus_we !== 1'b0 || bus_wstrb !== 4'h0) begin
            failures++;
            $display("FAIL load_c1 bus: got v%b st%b a%h we%b ws%h want 1 1 00400010 0 0",
                     bus_valid, core_stall, bus_addr, bus_we, bus_wstrb);
        end
        next_cycle();
        bus_ready = 1'b0;
        @(negedge clk);
        check_done("load");
    endtask

    task automatic test_store();
        int d0;
        bit stable = 1'b1;
        next_cycle();
        drive_req(32'h0040_0020, 1'b1, 32'h1234_5678, 4'b0011, 1'b1, 1'b0, model_rdata);
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            core_req = 1'b0; bus_ready = (i == 5); bus_rdata = 32'h5555_AAAA;
            @(negedge clk);
            if (bus_valid !== 1'b1 || bus_addr !== 32'h0040_0020 || bus_we !== 1'b1 ||
                bus_wdata !== 32'h1234_5678 || bus_wstrb !== 4'b0011 || core_done !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL store_stable: got v%b a%h we%b wd%h ws%h want 1 00400020 1 12345678 3",
                     bus_valid, bus_addr, bus_we, bus_wdata, bus_wstrb);
        end
        next_cycle();
        bus_ready = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        check_done("store");
        next_cycle();
        @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL store_pulses: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_cacheable();
        bit bad = 1'b0;
        int d0 = done_cnt;
        next_cycle();
        core_req = 1'b1; core_addr = 32'h8000_0000; core_we = 1'b0; cache_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (core_stall !== 1'b0 || bus_valid !== 1'b0 || core_done !== 1'b0) bad = 1'b1;
            next_cycle();
        end
        core_req = 1'b0; cache_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bad || bus_valid !== 1'b0 || done_cnt != d0) begin
            failures++;
            $display("FAIL cacheable: got bad=%b valid=%b dones=%0d want 0 0 0", bad, bus_valid, done_cnt - d0);
        end
    endtask

    task automatic test_timeout(input bit ready_on_limit);
        int  vcyc = 0;
        bit  seen = 1'b0;
        next_cycle();
        if (ready_on_limit)
            drive_req(32'h0040_0030, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hCAFE_0001);
        else
            drive_req(32'h0040_0030, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            core_req = 1'b0;
            bus_ready = ready_on_limit && (i == T + 1);
            bus_rdata = 32'hCAFE_0001;
            @(negedge clk);
            if (core_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus_valid === 1'b1) vcyc++;
        end
        bus_ready = 1'b0;
        checks++;
        if (vcyc != T + 1) begin
            failures++;
            $display("FAIL timeout_valid_cycles(rl=%0b): got %0d want %0d", ready_on_limit, vcyc, T + 1);
        end
        if (seen) begin
            check_done(ready_on_limit ? "limit_ready" : "timeout");
        end else begin
            checks++;
            failures++;
            $display("FAIL timeout_no_done: got none within budget want done");
        end
    endtask

    task automatic test_bus_err();
        next_cycle();
        drive_req(32'h0040_0040, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h1111_2222);
        next_cycle();
        core_req = 1'b0; bus_ready = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1111_2222;
        next_cycle();
        bus_ready = 1'b0; bus_err = 1'b0;
        @(negedge clk);
        check_done("bus_err");
    endtask

    task automatic test_reset_mid();
        int d0;
        next_cycle();
        drive_req(32'h0040_0050, 1'b1, 32'hAAAA_BBBB, 4'hF, 1'b0, 1'b0, 32'h0);
        next_cycle();
        core_req = 1'b0;
        next_cycle();
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_valid !== 1'b0 || bus_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: got valid=%b addr=%h want 0 0", bus_valid, bus_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (done_cnt != d0 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_done: got dones=%0d valid=%b want 0 0", done_cnt - d0, bus_valid);
        end
        model_rdata = 32'h0;
        next_cycle();
        drive_req(32'h0040_0060, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0BAD_F00D);
        next_cycle();
        core_req = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
        next_cycle();
        bus_ready = 1'b0;
        @(negedge clk);
        check_done("after_reset");
    endtask

    task automatic test_back_to_back();
        next_cycle();
        drive_req(32'h0040_0070, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_0A0A);
        next_cycle();
        bus_ready = 1'b1; bus_rdata = 32'h0000_0A0A;
        next_cycle();
        bus_ready = 1'b0;
        @(negedge clk);
        check_done("b2b_first");
        drive_req(32'h0040_0074, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_0B0B);
        next_cycle();
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b1 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_stall: got stall=%b valid=%b want 1 0", core_stall, bus_valid);
        end
        next_cycle();
        core_req = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h0000_0B0B;
        @(negedge clk);
        checks++;
        if (bus_valid !== 1'b1 || bus_addr !== 32'h0040_0074) begin
            failures++;
            $display("FAIL b2b_second_bus: got valid=%b addr=%h want 1 00400074", bus_valid, bus_addr);
        end
        next_cycle();
        bus_ready = 1'b0;
        @(negedge clk);
        check_done("b2b_second");
    endtask

    initial begin
        rst_n = 1'b0; core_req = 1'b0; core_addr = '0; core_we = 1'b0; core_wdata = '0;
        core_wstrb = '0; cache_enable = 1'b0; bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        test_reset();
        test_load();
        test_store();
        test_cacheable();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_bus_err();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uncached_bus_bridge
`default_nettype wire
